coin_accumulator: RTL and testbench
===================================

COIN_ACCUMULATOR -- requirements
Module: coin_accumulator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 200, is the number of idle cycles in COLLECT before an automatic refund.
REQ-002 Parameter MAX_VALUE, default 127, is the saturation ceiling for the accumulated total.
REQ-003 i_clk  input  1  the single clock; all logic is rising-edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_coin_valid  input  1  one-cycle pulse: a coin has been detected.
REQ-006 i_coin_type  input  2  coin denomination: 00=5, 01=10, 10=20, 11=50; sampled only when i_coin_valid=1.
REQ-007 i_cancel  input  1  user cancel request; level, sampled each cycle.
REQ-008 i_lock  input  1  one-cycle pulse from the vending FSM: the vend has started and the total is frozen.
REQ-009 i_consume  input  1  one-cycle pulse from the vending FSM: the vend has completed and the credit is spent.
REQ-010 i_release  input  1  one-cycle pulse from the vending FSM: the vend was aborted and the credit is returned to the user.
REQ-011 o_total_coin_value  output  7  accumulated credit; drives the vending FSM coin-value input.
REQ-012 o_coin_accept  output  1  one-cycle pulse: the coin was added.
REQ-013 o_coin_reject  output  1  one-cycle pulse: the coin was refused.
REQ-014 o_refund_valid  output  1  one-cycle pulse: o_refund_value is valid.
REQ-015 o_refund_value  output  7  amount to eject; held until the next refund.
REQ-016 o_state  output  2  current state: IDLE=00, COLLECT=01, LOCKED=10, REFUND=11.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 All pulse outputs SHALL assert in the cycle after the causing input is sampled.
REQ-019 IDLE: the total SHALL be 0. An accepted coin adds its value and moves the block to COLLECT. i_cancel, i_lock, i_consume and i_release are ignored in IDLE.
REQ-020 COLLECT priority, highest first:
- i_cancel -> REFUND
- i_lock -> LOCKED
- i_coin_valid -> add the coin and stay in COLLECT
- timeout -> REFUND
REQ-021 A coin is accepted only if total + value <= MAX_VALUE. Otherwise o_coin_reject pulses and the total is unchanged; the total never wraps.
REQ-022 The addition SHALL be computed at 8 bits before the compare.
REQ-023 A coin arriving in the same cycle as i_cancel or i_lock SHALL be rejected (o_coin_reject=1).
REQ-024 Idle counter: cleared on entry to COLLECT and on every accepted coin; increments each cycle in COLLECT. Reaching TIMEOUT_CYCLES-1 SHALL cause the transition to REFUND on the next edge.
REQ-025 LOCKED: every coin SHALL be rejected.
- i_consume -> IDLE, total cleared to 0, no refund.
- i_release -> COLLECT, total kept, idle counter cleared.
- i_consume and i_release in the same cycle: i_consume wins.
- i_cancel is ignored in LOCKED; the vending FSM owns cancel while a vend is in progress.
REQ-026 REFUND lasts exactly one cycle:
- o_refund_valid=1 and o_refund_value=total.
- Next state is IDLE with the total cleared.
- Coins arriving in REFUND are rejected.
REQ-027 o_total_coin_value SHALL equal the internal total at all times, including the REFUND cycle. It reads 0 from the first IDLE cycle after a refund or consume.
REQ-028 o_coin_accept and o_coin_reject SHALL never be asserted in the same cycle.
REQ-029 o_state changes only on a rising edge of i_clk or on reset.

Reset
REQ-030 On i_rst_n=0, regardless of the clock, the block SHALL be set to:
- state=IDLE
- total=0
- idle counter=0
- o_coin_accept, o_coin_reject and o_refund_valid = 0
- o_refund_value=0
REQ-031 Reset asserted in COLLECT or LOCKED SHALL discard the credit with no refund pulse.
REQ-032 Operation resumes on the first rising edge after i_rst_n returns to 1.

Verification
REQ-033 Accumulate: coins 10, 20 -> two accept pulses, total=30, state=COLLECT; then i_lock, i_consume -> state=LOCKED, then IDLE with total=0 and no refund.
REQ-034 Saturation: coins 50, 50, 20 -> total=120; a further coin 10 -> reject pulse, total stays 120; a further coin 5 -> accept, total=125.
REQ-035 Cancel with coin: total=60, i_cancel and a coin 5 in the same cycle -> reject pulse, o_refund_valid for one cycle with o_refund_value=60, then IDLE with total=0.
REQ-036 Timeout: TIMEOUT_CYCLES=8, a single coin 20 and then no activity -> REFUND with value 20 after exactly 8 cycles in COLLECT.
REQ-037 Lock/release: total=30, i_lock, coin 10 in LOCKED -> reject; i_release -> COLLECT with total=30; i_consume and i_release in the same cycle while LOCKED -> IDLE.
REQ-038 Reset mid-operation: total=45 in LOCKED, pulse i_rst_n low between clock edges -> outputs clear immediately, no refund pulse, state=IDLE.

Source files
------------

// File: rtl/coin_accumulator_if.sv
// -----------------------------------------------------------------------------
// coin_accumulator_if
// Purpose : groups the coin-acceptor handshake signals shared between the
//           coin_accumulator (slave side) and the vending controller / coin
//           mechanism (master side).
// Signals :
//   i_coin_valid        one-cycle pulse, a coin has been detected
//   i_coin_type [1:0]   denomination 00=5, 01=10, 10=20, 11=50
//   i_cancel            user cancel request (level)
//   i_lock              vend started, credit frozen (pulse)
//   i_consume           vend completed, credit spent (pulse)
//   i_release           vend aborted, credit returned to COLLECT (pulse)
//   o_total_coin_value  accumulated credit
//   o_coin_accept       coin added (pulse)
//   o_coin_reject       coin refused (pulse)
//   o_refund_valid      o_refund_value is valid (pulse)
//   o_refund_value      amount to eject, held until the next refund
//   o_state             IDLE=00, COLLECT=01, LOCKED=10, REFUND=11
// -----------------------------------------------------------------------------
interface coin_accumulator_if;
    logic       i_coin_valid;
    logic [1:0] i_coin_type;
    logic       i_cancel;
    logic       i_lock;
    logic       i_consume;
    logic       i_release;
    logic [6:0] o_total_coin_value;
    logic       o_coin_accept;
    logic       o_coin_reject;
    logic       o_refund_valid;
    logic [6:0] o_refund_value;
    logic [1:0] o_state;

    // Accumulator side: consumes requests, produces credit/status.
    modport slave (
        input  i_coin_valid, i_coin_type, i_cancel, i_lock, i_consume, i_release,
        output o_total_coin_value, o_coin_accept, o_coin_reject,
               o_refund_valid, o_refund_value, o_state
    );

    // Coin mechanism / vending controller side.
    modport master (
        output i_coin_valid, i_coin_type, i_cancel, i_lock, i_consume, i_release,
        input  o_total_coin_value, o_coin_accept, o_coin_reject,
               o_refund_valid, o_refund_value, o_state
    );
endinterface

// File: rtl/coin_accumulator.sv
// -----------------------------------------------------------------------------
// coin_accumulator
// Purpose : accumulates coin credit for a vending machine, saturating at
//           MAX_VALUE, with cancel/timeout refund and a lock/consume/release
//           handshake towards the vending FSM. All outputs are registered.
// Ports   :
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      coin_accumulator_if.slave (coin inputs, vend handshake, status)
// Parameters:
//   TIMEOUT_CYCLES  idle cycles in COLLECT before an automatic refund
//   MAX_VALUE       saturation ceiling of the accumulated total
// -----------------------------------------------------------------------------
module coin_accumulator #(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int MAX_VALUE      = 127
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    coin_accumulator_if.slave     bus
);

    localparam int              CNT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      MAX_VALUE_8 = 8'(MAX_VALUE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_LOCKED  = 2'b10,
        ST_REFUND  = 2'b11
    } state_t;

    // Denomination decode, widened to the 8-bit adder width.
    function automatic logic [7:0] coin_value(input logic [1:0] coin_type);
        logic [7:0] value;
        case (coin_type)
            2'b00:   value = 8'd5;
            2'b01:   value = 8'd10;
            2'b10:   value = 8'd20;
            2'b11:   value = 8'd50;
            default: value = 8'd0;
        endcase
        return value;
    endfunction

    state_t           state_q,        state_d;
    logic [6:0]       total_q,        total_d;
    logic [CNT_W-1:0] idle_q,         idle_d;
    logic             accept_q,       accept_d;
    logic             reject_q,       reject_d;
    logic             refund_valid_q, refund_valid_d;
    logic [6:0]       refund_value_q, refund_value_d;

    logic [7:0]       sum_s;
    logic             fits_s;

    // Candidate total at 8 bits so an overflowing coin can never wrap the compare.
    always_comb begin
        sum_s  = {1'b0, total_q} + coin_value(bus.i_coin_type);
        fits_s = (sum_s <= MAX_VALUE_8);
    end

    // Next-state and next-output logic for the credit FSM.
    always_comb begin
        state_d        = state_q;
        total_d        = total_q;
        idle_d         = idle_q;
        accept_d       = 1'b0;
        reject_d       = 1'b0;
        refund_valid_d = 1'b0;
        refund_value_d = refund_value_q;

        case (state_q)
            ST_IDLE: begin
                // Vend handshake and cancel have no meaning without credit.
                if (bus.i_coin_valid) begin
                    if (fits_s) begin
                        total_d  = sum_s[6:0];
                        accept_d = 1'b1;
                        idle_d   = '0;
                        state_d  = ST_COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else begin
                    total_d = 7'd0;
                end
            end

            ST_COLLECT: begin
                if (bus.i_cancel) begin
                    reject_d       = bus.i_coin_valid;
                    refund_valid_d = 1'b1;
                    refund_value_d = total_q;
                    state_d        = ST_REFUND;
                end else if (bus.i_lock) begin
                    reject_d = bus.i_coin_valid;
                    state_d  = ST_LOCKED;
                end else if (bus.i_coin_valid && fits_s) begin
                    total_d  = sum_s[6:0];
                    accept_d = 1'b1;
                    idle_d   = '0;
                end else begin
                    // A refused coin is not activity: the timeout keeps running.
                    reject_d = bus.i_coin_valid;
                    if (idle_q >= IDLE_LAST) begin
                        refund_valid_d = 1'b1;
                        refund_value_d = total_q;
                        state_d        = ST_REFUND;
                    end else begin
                        idle_d = idle_q + CNT_W'(1);
                    end
                end
            end

            ST_LOCKED: begin
                // Cancel belongs to the vending FSM while a vend is in flight.
                reject_d = bus.i_coin_valid;
                if (bus.i_consume) begin
                    total_d = 7'd0;
                    state_d = ST_IDLE;
                end else if (bus.i_release) begin
                    idle_d  = '0;
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_LOCKED;
                end
            end

            ST_REFUND: begin
                // Total stays visible during the refund cycle, cleared on exit.
                reject_d = bus.i_coin_valid;
                total_d  = 7'd0;
                idle_d   = '0;
                state_d  = ST_IDLE;
            end

            default: begin
                total_d = 7'd0;
                idle_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, credit and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            total_q        <= 7'd0;
            idle_q         <= '0;
            accept_q       <= 1'b0;
            reject_q       <= 1'b0;
            refund_valid_q <= 1'b0;
            refund_value_q <= 7'd0;
        end else begin
            state_q        <= state_d;
            total_q        <= total_d;
            idle_q         <= idle_d;
            accept_q       <= accept_d;
            reject_q       <= reject_d;
            refund_valid_q <= refund_valid_d;
            refund_value_q <= refund_value_d;
        end
    end

    assign bus.o_state            = state_q;
    assign bus.o_total_coin_value = total_q;
    assign bus.o_coin_accept      = accept_q;
    assign bus.o_coin_reject      = reject_q;
    assign bus.o_refund_valid     = refund_valid_q;
    assign bus.o_refund_value     = refund_value_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// -----------------------------------------------------------------------------
// tb_coin_accumulator
// Directed scenarios followed by a randomized run, every cycle compared
// against a behavioural credit model kept in integer arithmetic.
// -----------------------------------------------------------------------------
module tb_coin_accumulator;

    localparam int TMO = 8;
    localparam int MAXV = 127;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;

    coin_accumulator_if bus ();

    coin_accumulator #(
        .TIMEOUT_CYCLES (TMO),
        .MAX_VALUE      (MAXV)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Behavioural model: phase 0=idle, 1=collecting, 2=locked, 3=refunding.
    int coin_tbl [4] = '{5, 10, 20, 50};
    int m_phase, m_total, m_idle, m_acc, m_rej, m_rv, m_rval;

    task automatic model_reset();
        m_phase = 0; m_total = 0; m_idle = 0;
        m_acc = 0; m_rej = 0; m_rv = 0; m_rval = 0;
    endtask

    task automatic model_edge(input logic cv, input logic [1:0] ct,
                              input logic ca, input logic lk,
                              input logic cs, input logic rl);
        int  val;
        bit  fits;
        bit  took;
        val  = coin_tbl[ct];
        fits = (m_total + val) <= MAXV;
        took = 0;
        m_acc = 0; m_rej = 0; m_rv = 0;
        if (m_phase == 0) begin
            if (cv) begin
                if (fits) begin
                    m_total = m_total + val; m_acc = 1; m_idle = 0; m_phase = 1;
                end else m_rej = 1;
            end
        end else if (m_phase == 1) begin
            if (ca) begin
                m_rej = cv; m_rv = 1; m_rval = m_total; m_phase = 3;
            end else if (lk) begin
                m_rej = cv; m_phase = 2;
            end else begin
                if (cv) begin
                    if (fits) begin
                        m_total = m_total + val; m_acc = 1; m_idle = 0; took = 1;
                    end else m_rej = 1;
                end
                if (!took) begin
                    if (m_idle == TMO - 1) begin
                        m_rv = 1; m_rval = m_total; m_phase = 3;
                    end else m_idle = m_idle + 1;
                end
            end
        end else if (m_phase == 2) begin
            m_rej = cv;
            if (cs) begin
                m_total = 0; m_phase = 0;
            end else if (rl) begin
                m_idle = 0; m_phase = 1;
            end
        end else begin
            m_rej = cv; m_total = 0; m_phase = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},  32'(bus.o_state),            32'(m_phase));
        chk({tag, ".total"},  32'(bus.o_total_coin_value), 32'(m_total));
        chk({tag, ".accept"}, 32'(bus.o_coin_accept),      32'(m_acc));
        chk({tag, ".reject"}, 32'(bus.o_coin_reject),      32'(m_rej));
        chk({tag, ".rvalid"}, 32'(bus.o_refund_valid),     32'(m_rv));
        chk({tag, ".rvalue"}, 32'(bus.o_refund_value),     32'(m_rval));
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare at +1.
    task automatic step(input string tag, input logic cv, input logic [1:0] ct,
                        input logic ca, input logic lk, input logic cs, input logic rl);
        bus.i_coin_valid = cv;
        bus.i_coin_type  = ct;
        bus.i_cancel     = ca;
        bus.i_lock       = lk;
        bus.i_consume    = cs;
        bus.i_release    = rl;
        @(posedge i_clk);
        model_edge(cv, ct, ca, lk, cs, rl);
        #1;
        check_all(tag);
    endtask

    task automatic coin(input string tag, input logic [1:0] ct);
        step(tag, 1'b1, ct, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        logic cv, ca, lk, cs, rl;
        logic [1:0] ct;

        bus.i_coin_valid = 1'b0;
        bus.i_coin_type  = 2'b00;
        bus.i_cancel     = 1'b0;
        bus.i_lock       = 1'b0;
        bus.i_consume    = 1'b0;
        bus.i_release    = 1'b0;
        model_reset();

        // Reset state
        #12;
        check_all("reset");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Accumulate then vend
        coin("acc_c10", 2'b01);
        coin("acc_c20", 2'b10);
        chk("acc_total30", 32'(bus.o_total_coin_value), 32'd30);
        step("acc_lock", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("acc_locked", 32'(bus.o_state), 32'd2);
        step("acc_consume", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("acc_idle_total", 32'(bus.o_total_coin_value), 32'd0);
        chk("acc_no_refund", 32'(bus.o_refund_valid), 32'd0);

        // Saturation
        coin("sat_c50a", 2'b11);
        coin("sat_c50b", 2'b11);
        coin("sat_c20", 2'b10);
        chk("sat_total120", 32'(bus.o_total_coin_value), 32'd120);
        coin("sat_c10", 2'b01);
        chk("sat_reject", 32'(bus.o_coin_reject), 32'd1);
        chk("sat_hold120", 32'(bus.o_total_coin_value), 32'd120);
        coin("sat_c5", 2'b00);
        chk("sat_total125", 32'(bus.o_total_coin_value), 32'd125);
        step("sat_cancel", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_refund125", 32'(bus.o_refund_value), 32'd125);
        idle("sat_idle");

        // Cancel with coin in the same cycle
        coin("can_c50", 2'b11);
        coin("can_c10", 2'b01);
        step("can_cancel_coin", 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("can_reject", 32'(bus.o_coin_reject), 32'd1);
        chk("can_rvalid", 32'(bus.o_refund_valid), 32'd1);
        chk("can_rvalue60", 32'(bus.o_refund_value), 32'd60);
        chk("can_total_visible", 32'(bus.o_total_coin_value), 32'd60);
        idle("can_after");
        chk("can_total0", 32'(bus.o_total_coin_value), 32'd0);
        chk("can_rvalid_low", 32'(bus.o_refund_valid), 32'd0);

        // Timeout after exactly TMO cycles in COLLECT
        coin("tmo_c20", 2'b10);
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            idle("tmo_wait");
            n++;
            if (bus.o_refund_valid === 1'b1) seen = 1'b1;
        end
        chk("tmo_cycles", 32'(n), 32'(TMO));
        chk("tmo_value20", 32'(bus.o_refund_value), 32'd20);
        idle("tmo_after");

        // Lock / release
        coin("lr_c10", 2'b01);
        coin("lr_c20", 2'b10);
        step("lr_lock", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        coin("lr_coin_locked", 2'b01);
        chk("lr_reject", 32'(bus.o_coin_reject), 32'd1);
        step("lr_cancel_ignored", 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lr_release", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lr_collect", 32'(bus.o_state), 32'd1);
        chk("lr_total30", 32'(bus.o_total_coin_value), 32'd30);
        step("lr_lock2", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        step("lr_both", 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("lr_both_idle", 32'(bus.o_state), 32'd0);

        // Asynchronous reset while LOCKED with credit 45
        coin("rst_c20a", 2'b10);
        coin("rst_c20b", 2'b10);
        coin("rst_c5", 2'b00);
        step("rst_lock", 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst_pre45", 32'(bus.o_total_coin_value), 32'd45);
        #2;
        i_rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        #1;
        i_rst_n = 1'b1;
        idle("rst_resume");
        chk("rst_no_refund", 32'(bus.o_refund_valid), 32'd0);

        // Randomized traffic with occasional quiet stretches to hit timeouts
        for (int i = 0; i < 400; i++) begin
            cv = 1'($urandom_range(0, 1));
            ct = 2'($urandom_range(0, 3));
            ca = 1'($urandom_range(0, 19) == 0);
            lk = 1'($urandom_range(0, 9) == 0);
            cs = 1'($urandom_range(0, 5) == 0);
            rl = 1'($urandom_range(0, 5) == 0);
            step("rand", cv, ct, ca, lk, cs, rl);
            if ($urandom_range(0, 29) == 0) begin
                for (int j = 0; j < 10; j++) idle("rand_quiet");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
